// File: rtl/counter_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : counter_sequencer_if
//  Purpose  : Host control, counter datapath and status bundle for the
//             counter run sequencer.
//  Revision : 1.0  initial release
// ============================================================================
interface counter_sequencer_if #(
    parameter int WIDTH = 4,
    parameter int REP_W = 4
);
    logic             start;
    logic             stop;
    logic             pause;
    logic [WIDTH-1:0] term;
    logic [REP_W-1:0] reps;
    logic [WIDTH-1:0] cnt_q;
    logic             cnt_clr;
    logic             cnt_en;
    logic             tick;
    logic             done;
    logic             busy;
    logic [REP_W-1:0] pass_cnt;

    // Master is the host plus counter side; slave is the sequencer itself.
    modport master (
        output start, stop, pause, term, reps, cnt_q,
        input  cnt_clr, cnt_en, tick, done, busy, pass_cnt
    );

    modport slave (
        input  start, stop, pause, term, reps, cnt_q,
        output cnt_clr, cnt_en, tick, done, busy, pass_cnt
    );
endinterface
`default_nettype wire

// File: rtl/counter_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : counter_sequencer
//  Purpose  : Sequences clear/enable of an external up counter through a
//             programmed number of 0..term passes, with pause and abort.
//  Revision : 1.0  initial release
// ============================================================================
module counter_sequencer #(
    parameter int WIDTH = 4,
    parameter int REP_W = 4
) (
    input  wire logic          clk,
    input  wire logic          reset_n,
    counter_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        c_IDLE  = 2'd0,
        c_CLEAR = 2'd1,
        c_RUN   = 2'd2,
        c_DONE  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [REP_W-1:0] r_pass_cnt;
    logic [REP_W-1:0] w_pass_cnt_nxt;
    logic [REP_W-1:0] w_pass_inc;
    logic [WIDTH-1:0] r_term_l;
    logic [REP_W-1:0] r_reps_l;
    logic             w_latch;
    logic             w_at_term;
    logic             w_last_pass;
    logic             w_cnt_clr;
    logic             w_cnt_en;
    logic             w_tick;

    assign w_pass_inc  = r_pass_cnt + {{(REP_W-1){1'b0}}, 1'b1};
    assign w_at_term   = (bus.cnt_q == r_term_l);
    // A zero repetition count means the run only ends on stop.
    assign w_last_pass = (r_reps_l != '0) && (w_pass_inc == r_reps_l);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= c_IDLE;
            r_pass_cnt <= '0;
            r_term_l   <= '0;
            r_reps_l   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_pass_cnt <= w_pass_cnt_nxt;
            if (w_latch) begin
                r_term_l <= bus.term;
                r_reps_l <= bus.reps;
            end
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_pass_cnt_nxt = r_pass_cnt;
        w_latch        = 1'b0;
        w_cnt_clr      = 1'b0;
        w_cnt_en       = 1'b0;
        w_tick         = 1'b0;

        case (r_state)
            c_IDLE: begin
                if (bus.start) begin
                    w_latch        = 1'b1;
                    w_pass_cnt_nxt = '0;
                    w_state_nxt    = c_CLEAR;
                end
            end
            c_CLEAR: begin
                w_cnt_clr   = 1'b1;
                w_state_nxt = c_RUN;
            end
            c_RUN: begin
                if (!bus.pause) begin
                    if (!w_at_term) begin
                        w_cnt_en = 1'b1;
                    end else begin
                        w_tick         = 1'b1;
                        w_pass_cnt_nxt = w_pass_inc;
                        if (w_last_pass) begin
                            w_state_nxt = c_DONE;
                        end else begin
                            // Restart from zero so each pass lasts term+1 cycles.
                            w_cnt_clr = 1'b1;
                        end
                    end
                end
            end
            c_DONE: begin
                w_state_nxt = c_IDLE;
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase

        // Abort wins over everything; completed-pass count is kept for the host.
        if (bus.stop) begin
            w_state_nxt    = c_IDLE;
            w_pass_cnt_nxt = r_pass_cnt;
            w_latch        = 1'b0;
            w_cnt_clr      = 1'b0;
            w_cnt_en       = 1'b0;
            w_tick         = 1'b0;
        end
    end

    assign bus.cnt_clr  = w_cnt_clr;
    assign bus.cnt_en   = w_cnt_en;
    assign bus.tick     = w_tick;
    assign bus.done     = (r_state == c_DONE);
    assign bus.busy     = (r_state != c_IDLE);
    assign bus.pass_cnt = r_pass_cnt;

endmodule
`default_nettype wire

// File: tb/tb_counter_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_counter_sequencer
//  Purpose  : Random-stimulus bench pairing the sequencer with a counter
//             model and a run-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_counter_sequencer;
    localparam int WIDTH   = 4;
    localparam int REP_W   = 4;
    localparam int C_QMOD  = 1 << WIDTH;
    localparam int C_PMOD  = 1 << REP_W;
    localparam int C_NCYC  = 4000;

    logic clk = 1'b0;
    logic reset_n;
    logic [WIDTH-1:0] r_q;

    always #5 clk = ~clk;

    counter_sequencer_if #(.WIDTH(WIDTH), .REP_W(REP_W)) bus ();

    counter_sequencer #(.WIDTH(WIDTH), .REP_W(REP_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Counter datapath: clear has priority over enable.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)         r_q <= '0;
        else if (bus.cnt_clr) r_q <= '0;
        else if (bus.cnt_en)  r_q <= r_q + 1'b1;
    end
    assign bus.cnt_q = r_q;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Run-level reference: a run is in progress, first cycle clears, the
    // cycle after the final pass reports done.
    bit m_in_run, m_clearing, m_finishing;
    int m_term, m_reps, m_passes, m_q;
    bit e_clr, e_en, e_tick, e_done, e_busy;

    task automatic model_reset();
        m_in_run = 0; m_clearing = 0; m_finishing = 0;
        m_term = 0; m_reps = 0; m_passes = 0; m_q = 0;
    endtask

    task automatic check_all_low(input string tag);
        check({tag, ".cnt_clr"},  32'(bus.cnt_clr),  32'd0);
        check({tag, ".cnt_en"},   32'(bus.cnt_en),   32'd0);
        check({tag, ".tick"},     32'(bus.tick),     32'd0);
        check({tag, ".done"},     32'(bus.done),     32'd0);
        check({tag, ".busy"},     32'(bus.busy),     32'd0);
        check({tag, ".pass_cnt"}, 32'(bus.pass_cnt), 32'd0);
        check({tag, ".cnt_q"},    32'(bus.cnt_q),    32'd0);
    endtask

    initial begin
        int v;
        reset_n   = 1'b0;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        bus.pause = 1'b0;
        bus.term  = '0;
        bus.reps  = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_low("reset");
        reset_n = 1'b1;

        for (int cyc = 0; cyc < C_NCYC; cyc++) begin
            @(posedge clk);
            #1;
            if (cyc % 613 == 300) begin
                bus.start = 1'b0;
                bus.stop  = 1'b0;
                bus.pause = 1'b0;
                reset_n   = 1'b0;
                #1;
                check_all_low("async_reset");
                @(negedge clk);
                reset_n = 1'b1;
                model_reset();
                continue;
            end

            bus.start = ($urandom_range(0, 99) < 30);
            bus.stop  = ($urandom_range(0, 99) < 3);
            bus.pause = ($urandom_range(0, 99) < 20);
            v         = $urandom_range(0, 9);
            bus.term  = (v < 8) ? WIDTH'(v) : WIDTH'(C_QMOD - 1);
            bus.reps  = REP_W'($urandom_range(0, 3));

            e_clr  = 0; e_en = 0; e_tick = 0;
            e_done = m_finishing;
            e_busy = m_in_run;
            if (!bus.stop && m_in_run) begin
                if (m_clearing) begin
                    e_clr = 1;
                end else if (!m_finishing && !bus.pause) begin
                    if (m_q == m_term) begin
                        e_tick = 1;
                        e_clr  = !(m_reps != 0 && (m_passes + 1) % C_PMOD == m_reps);
                    end else begin
                        e_en = 1;
                    end
                end
            end

            @(negedge clk);
            check("cnt_clr",  32'(bus.cnt_clr),  32'(e_clr));
            check("cnt_en",   32'(bus.cnt_en),   32'(e_en));
            check("tick",     32'(bus.tick),     32'(e_tick));
            check("done",     32'(bus.done),     32'(e_done));
            check("busy",     32'(bus.busy),     32'(e_busy));
            check("pass_cnt", 32'(bus.pass_cnt), 32'(m_passes));
            check("cnt_q",    32'(bus.cnt_q),    32'(m_q));

            if (e_clr)      m_q = 0;
            else if (e_en)  m_q = (m_q + 1) % C_QMOD;

            if (bus.stop) begin
                m_in_run = 0; m_clearing = 0; m_finishing = 0;
            end else if (!m_in_run) begin
                if (bus.start) begin
                    m_term   = int'(bus.term);
                    m_reps   = int'(bus.reps);
                    m_passes = 0;
                    m_in_run = 1;
                    m_clearing = 1;
                end
            end else if (m_clearing) begin
                m_clearing = 0;
            end else if (m_finishing) begin
                m_finishing = 0;
                m_in_run    = 0;
            end else if (e_tick) begin
                m_passes = (m_passes + 1) % C_PMOD;
                if (m_reps != 0 && m_passes == m_reps) m_finishing = 1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
